ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device transmitter for the PS/2 keyboard port; the send-direction counterpart of the existing PS/2 scan-code receive path.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) using the PS/2 host request-to-send sequence: odd parity, device-clocked bits, device ACK check.
- Sits beside the receiver on the shared PS/2 lines in the clock_50 domain and drives both lines as open-drain.

Parameters:
- INHIBIT_CYCLES, 5000, cycles clk is held low before start (100 us at 50 MHz).
- CLK_TIMEOUT, 750000, maximum cycles from clock release to the first device falling edge (15 ms).
- FRAME_TIMEOUT, 100000, maximum cycles from the first falling edge to ACK sampled (2 ms).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low (0 = reset).
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid & tx_ready.
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous).
- ps2_dat_in  in  1  raw PS/2 data line (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release.
- ps2_dat_oe  out  1  1 = pull PS/2 data low; 0 = release.
- busy  out  1  high in every state except IDLE; the receiver ignores the lines while busy.
- tx_done  out  1  one-cycle pulse when the device ACKs.
- tx_error  out  1  one-cycle pulse on a timeout or a missing ACK.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Outputs: ps2_clk_oe=0, ps2_dat_oe=0, tx_done=0, tx_error=0, busy=0, tx_ready=1.
  - State=IDLE; bit counter, shift register and timer cleared.
  - Reset mid-frame releases both lines at that same edge.
- Input sampling: ps2_clk_in and ps2_dat_in pass through a 2-FF synchronizer. A falling edge (fe) is prev=1, cur=0 on the synchronized clock.
- Byte accept:
  - On tx_valid & tx_ready, latch the frame {parity, tx_data}, where parity = ~^tx_data (odd parity).
  - Next cycle: INHIBIT, ps2_clk_oe=1.
  - tx_valid outside IDLE is ignored.
- INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles. fe is ignored here because the host is driving the clock. Then go to REQ.
- REQ:
  - In one cycle: ps2_dat_oe=1 (start bit 0), ps2_clk_oe=0, timer cleared.
  - Go to WAIT_CLK.
- WAIT_CLK:
  - First fe: drive bit0 (dat_oe = ~bit0), bitcnt=1, timer cleared, go to DATA.
  - Timer reaching CLK_TIMEOUT: go to ERROR.
- DATA: on each fe, drive the next bit, LSB first. bit1..bit7 are driven on fe 2..8, then parity on fe 9. The data line changes only in the cycle after a detected fe.
- STOP: on fe 10, dat_oe=0 (release, stop bit 1). Go to ACK.
- ACK:
  - On fe 11, sample synchronized data. 0 goes to WAIT_IDLE; 1 goes to ERROR.
- WAIT_IDLE: wait until synchronized clock and data are both 1, then pulse tx_done and return to IDLE.
- FRAME_TIMEOUT: the timer runs from the first fe through WAIT_IDLE. Expiry in DATA, STOP, ACK or WAIT_IDLE goes to ERROR.
- ERROR:
  - Both oe=0; tx_error pulses for 1 cycle.
  - Then IDLE. No retry; the retry policy belongs to the caller.
- tx_done and tx_error are never high in the same cycle.
- Timer: 20-bit saturating counter, cleared on every state entry except DATA/STOP/ACK/WAIT_IDLE, which share the frame timer.
- Bit counter: 4 bits, counts fe 1..11; no wrap, since exit occurs at 11.
- Minimum accept-to-done latency: INHIBIT_CYCLES + 1 + 11 device clock periods + sync delay.

Decomposition:
- Shared package ps2_pkg:
  - State enum: IDLE, INHIBIT, REQ, WAIT_CLK, DATA, STOP, ACK, WAIT_IDLE, ERROR.
  - Default cycle constants for 50 MHz.
  - PS/2 command constants: CMD_SET_LEDS=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF.
- Sub-module ps2_sync_edge: 2-FF synchronizer for clk and data plus the falling-edge detect. It can be reused by the receive path.

Test Plan:
1. Send 0xF4 to a device model clocking at 12.5 kHz that ACKs. Required:
   - clk_oe high for exactly 5000 cycles.
   - Then dat_oe=1 and clk_oe=0 in the same cycle.
   - Model samples bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
   - tx_done pulses once; tx_ready returns to 1.
2. Send 0xED (six ones). Model sees parity bit 1; then tx_done.
3. Model leaves data high on clock 11 (no ACK). Required: tx_error pulses exactly once, no tx_done, both oe=0.
4. Model never clocks after REQ. Required: tx_error exactly CLK_TIMEOUT cycles after entering WAIT_CLK (±1 cycle for sync), with lines released.
5. Drive reset=0 after fe 5 (mid-DATA). Required: at the next edge both oe=0, busy=0, tx_ready=1; after reset=1, a new 0xFF send completes normally.
6. Hold tx_valid high with 0xAA while busy sending 0xF4. Required: 0xAA is not accepted until tx_ready=1, then is sent as a second complete frame.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, 50 MHz timing defaults and
// the keyboard command bytes the host commonly sends.
package ps2_pkg;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      INHIBIT   = 4'd1,
      REQ       = 4'd2,
      WAIT_CLK  = 4'd3,
      DATA      = 4'd4,
      STOP      = 4'd5,
      ACK       = 4'd6,
      WAIT_IDLE = 4'd7,
      ERROR     = 4'd8
   } ps2_tx_state_e;

   localparam int unsigned TIMER_W            = 20;
   localparam int unsigned INHIBIT_CYCLES_50M = 5000;
   localparam int unsigned CLK_TIMEOUT_50M    = 750000;
   localparam int unsigned FRAME_TIMEOUT_50M  = 100000;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;

   // PS/2 frames carry odd parity over the eight data bits.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte-level request/status handshake between a command source and the
// PS/2 host transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       tx_done;
   logic       tx_error;

   modport master (output tx_data, tx_valid, input tx_ready, busy, tx_done, tx_error);
   modport slave  (input tx_data, tx_valid, output tx_ready, busy, tx_done, tx_error);
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a
// falling-edge strobe on the synchronized clock.
module ps2_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk_in,
   input  logic ps2_dat_in,
   output logic clk_sync,
   output logic dat_sync,
   output logic clk_fe
);

   logic [1:0] clk_meta_r;
   logic [1:0] dat_meta_r;
   logic       clk_prev_r;

   // Idle-high reset values keep a spurious edge from appearing after reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         clk_meta_r <= 2'b11;
         dat_meta_r <= 2'b11;
         clk_prev_r <= 1'b1;
      end else begin
         clk_meta_r <= {clk_meta_r[0], ps2_clk_in};
         dat_meta_r <= {dat_meta_r[0], ps2_dat_in};
         clk_prev_r <= clk_meta_r[1];
      end
   end

   assign clk_sync = clk_meta_r[1];
   assign dat_sync = dat_meta_r[1];
   assign clk_fe   = clk_prev_r & ~clk_meta_r[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift
// the byte out on device clock edges and check the device ACK.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_50M,
   parameter int unsigned CLK_TIMEOUT    = CLK_TIMEOUT_50M,
   parameter int unsigned FRAME_TIMEOUT  = FRAME_TIMEOUT_50M
) (
   input  logic         clk,
   input  logic         reset,
   ps2_host_tx_if.slave tx,
   input  logic         ps2_clk_in,
   input  logic         ps2_dat_in,
   output logic         ps2_clk_oe,
   output logic         ps2_dat_oe
);

   localparam logic [19:0] TIMER_MAX    = 20'hFFFFF;
   localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 32'd1);
   localparam logic [19:0] CLK_LAST     = 20'(CLK_TIMEOUT - 32'd1);
   localparam logic [19:0] FRAME_LAST   = 20'(FRAME_TIMEOUT - 32'd1);

   ps2_tx_state_e state_r, state_s;
   logic [19:0]   timer_r, timer_s;
   logic [3:0]    bitcnt_r, bitcnt_s;
   logic [8:0]    shift_r, shift_s;
   logic          clk_oe_r, clk_oe_s, dat_oe_r, dat_oe_s;
   logic          done_r, done_s, error_r, error_s;
   logic          ready_r, busy_r;
   logic          clk_sync_s, dat_sync_s, clk_fe_s, frame_expired_s;

   ps2_sync_edge u_sync (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .clk_sync  (clk_sync_s),
      .dat_sync  (dat_sync_s),
      .clk_fe    (clk_fe_s)
   );

   // Next state, line drive and status pulses; the oe outputs are registered.
   always_comb begin
      state_s         = state_r;
      timer_s         = (timer_r == TIMER_MAX) ? timer_r : timer_r + 20'd1;
      bitcnt_s        = bitcnt_r;
      shift_s         = shift_r;
      clk_oe_s        = clk_oe_r;
      dat_oe_s        = dat_oe_r;
      done_s          = 1'b0;
      error_s         = 1'b0;
      frame_expired_s = (timer_r >= FRAME_LAST);
      case (state_r)
         IDLE: begin
            clk_oe_s = 1'b0;
            dat_oe_s = 1'b0;
            timer_s  = 20'd0;
            bitcnt_s = 4'd0;
            if (tx.tx_valid) begin
               shift_s  = {odd_parity(tx.tx_data), tx.tx_data};
               clk_oe_s = 1'b1;
               state_s  = INHIBIT;
            end else begin
               shift_s = 9'd0;
            end
         end
         INHIBIT: begin
            if (timer_r >= INHIBIT_LAST) begin
               clk_oe_s = 1'b0;
               dat_oe_s = 1'b1;
               timer_s  = 20'd0;
               state_s  = REQ;
            end else begin
               clk_oe_s = 1'b1;
            end
         end
         REQ: begin
            timer_s = 20'd0;
            state_s = WAIT_CLK;
         end
         WAIT_CLK: begin
            if (clk_fe_s) begin
               dat_oe_s = ~shift_r[0];
               shift_s  = {1'b0, shift_r[8:1]};
               bitcnt_s = 4'd1;
               timer_s  = 20'd0;
               state_s  = DATA;
            end else if (timer_r >= CLK_LAST) begin
               {clk_oe_s, dat_oe_s, error_s, timer_s, state_s} = {1'b0, 1'b0, 1'b1, 20'd0, ERROR};
            end else begin
               state_s = WAIT_CLK;
            end
         end
         DATA: begin
            if (frame_expired_s) begin
               {clk_oe_s, dat_oe_s, error_s, timer_s, state_s} = {1'b0, 1'b0, 1'b1, 20'd0, ERROR};
            end else if (clk_fe_s) begin
               // Eight shifts in, shift_r[0] holds the parity bit for fe 9.
               dat_oe_s = ~shift_r[0];
               shift_s  = {1'b0, shift_r[8:1]};
               bitcnt_s = bitcnt_r + 4'd1;
               state_s  = (bitcnt_r == 4'd8) ? STOP : DATA;
            end else begin
               state_s = DATA;
            end
         end
         STOP: begin
            if (frame_expired_s) begin
               {clk_oe_s, dat_oe_s, error_s, timer_s, state_s} = {1'b0, 1'b0, 1'b1, 20'd0, ERROR};
            end else if (clk_fe_s) begin
               dat_oe_s = 1'b0;
               bitcnt_s = bitcnt_r + 4'd1;
               state_s  = ACK;
            end else begin
               state_s = STOP;
            end
         end
         ACK: begin
            if (frame_expired_s) begin
               {clk_oe_s, dat_oe_s, error_s, timer_s, state_s} = {1'b0, 1'b0, 1'b1, 20'd0, ERROR};
            end else if (clk_fe_s) begin
               bitcnt_s = bitcnt_r + 4'd1;
               if (!dat_sync_s) begin
                  state_s = WAIT_IDLE;
               end else begin
                  {clk_oe_s, dat_oe_s, error_s, timer_s, state_s} = {1'b0, 1'b0, 1'b1, 20'd0, ERROR};
               end
            end else begin
               state_s = ACK;
            end
         end
         WAIT_IDLE: begin
            if (frame_expired_s) begin
               {clk_oe_s, dat_oe_s, error_s, timer_s, state_s} = {1'b0, 1'b0, 1'b1, 20'd0, ERROR};
            end else if (clk_sync_s && dat_sync_s) begin
               done_s  = 1'b1;
               timer_s = 20'd0;
               state_s = IDLE;
            end else begin
               state_s = WAIT_IDLE;
            end
         end
         ERROR: begin
            clk_oe_s = 1'b0;
            dat_oe_s = 1'b0;
            timer_s  = 20'd0;
            state_s  = IDLE;
         end
         default: begin
            clk_oe_s = 1'b0;
            dat_oe_s = 1'b0;
            timer_s  = 20'd0;
            state_s  = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset releases both lines immediately.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r  <= IDLE;
         timer_r  <= 20'd0;
         bitcnt_r <= 4'd0;
         shift_r  <= 9'd0;
         clk_oe_r <= 1'b0;
         dat_oe_r <= 1'b0;
         done_r   <= 1'b0;
         error_r  <= 1'b0;
         ready_r  <= 1'b1;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         timer_r  <= timer_s;
         bitcnt_r <= bitcnt_s;
         shift_r  <= shift_s;
         clk_oe_r <= clk_oe_s;
         dat_oe_r <= dat_oe_s;
         done_r   <= done_s;
         error_r  <= error_s;
         ready_r  <= (state_s == IDLE);
         busy_r   <= (state_s != IDLE);
      end
   end

   assign ps2_clk_oe  = clk_oe_r;
   assign ps2_dat_oe  = dat_oe_r;
   assign tx.tx_ready = ready_r;
   assign tx.busy     = busy_r;
   assign tx.tx_done  = done_r;
   assign tx.tx_error = error_r;

endmodule
